// File: rtl/reg_c.sv
// Register C: load-enabled holding register for the DDR3 controller datapath.
// Captures dataCin when loadC is high at a rising edge; dataCvalid marks a load since reset.
module reg_c #(
  parameter int                 WIDTH     = 32,
  parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadC,
  input  logic [WIDTH-1:0] dataCin,
  output logic [WIDTH-1:0] dataCout,
  output logic             dataCvalid
);

  logic [WIDTH-1:0] data_r;
  logic             valid_r;
  logic [WIDTH-1:0] data_next_s;
  logic             valid_next_s;

  // Next-state selection: capture on load, otherwise hold.
  always_comb begin
    data_next_s  = data_r;
    valid_next_s = valid_r;
    if (loadC) begin
      data_next_s  = dataCin;
      valid_next_s = 1'b1;
    end else begin
      data_next_s  = data_r;
      valid_next_s = valid_r;
    end
  end

  // State flops with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= RESET_VAL;
      valid_r <= 1'b0;
    end else begin
      data_r  <= data_next_s;
      valid_r <= valid_next_s;
    end
  end

  assign dataCout   = data_r;
  assign dataCvalid = valid_r;

endmodule

// File: tb/tb_reg_c.sv
// Self-checking bench for reg_c: reset behaviour, a table of load/hold vectors,
// and hand-written sequences for asynchronous reset and first edge after release.
module tb_reg_c;

  logic        clk;
  logic        rst_n;
  logic        loadC;
  logic [31:0] dataCin;
  logic [31:0] dataCout;
  logic        dataCvalid;

  int tests;
  int fails;

  typedef struct {
    logic        load;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[10];

  reg_c #(.WIDTH(32), .RESET_VAL(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .loadC      (loadC),
    .dataCin    (dataCin),
    .dataCout   (dataCout),
    .dataCvalid (dataCvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_both(input string name, input logic [31:0] exp_out, input logic exp_valid);
    check({name, ".dataCout"}, dataCout, exp_out);
    check({name, ".dataCvalid"}, {31'd0, dataCvalid}, {31'd0, exp_valid});
  endtask

  initial begin
    tests = 0;
    fails = 0;

    vecs[0] = '{1'b1, 32'h00f4_30fe, 32'h00f4_30fe, 1'b1};  // basic load
    vecs[1] = '{1'b0, 32'h1234_0fe6, 32'h00f4_30fe, 1'b1};  // hold
    vecs[2] = '{1'b0, 32'h1234_0fe6, 32'h00f4_30fe, 1'b1};
    vecs[3] = '{1'b0, 32'h1234_0fe6, 32'h00f4_30fe, 1'b1};
    vecs[4] = '{1'b1, 32'h1234_0fe6, 32'h1234_0fe6, 1'b1};  // reload
    vecs[5] = '{1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1};  // back-to-back
    vecs[6] = '{1'b1, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1};
    vecs[7] = '{1'b1, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1};  // same value again
    vecs[8] = '{1'b1, 32'h1234_0fe6, 32'h1234_0fe6, 1'b1};
    vecs[9] = '{1'b0, 32'hFFFF_FFFF, 32'h1234_0fe6, 1'b1};  // hold with new input

    // Reset held with load active and all-ones data
    rst_n   = 1'b0;
    loadC   = 1'b1;
    dataCin = 32'hFFFF_FFFF;
    #1;
    check_both("reset_initial", 32'h0000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_both($sformatf("reset_edge%0d", i), 32'h0000_0000, 1'b0);
    end

    // Release reset mid-cycle with load off
    @(negedge clk);
    loadC   = 1'b0;
    dataCin = 32'h0000_0000;
    rst_n   = 1'b1;
    @(posedge clk);
    #1;
    check_both("post_release_idle", 32'h0000_0000, 1'b0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      loadC   = vecs[i].load;
      dataCin = vecs[i].din;
      @(posedge clk);
      #1;
      check_both($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
    end

    // Async reset between edges while loadC is high
    @(negedge clk);
    loadC   = 1'b1;
    dataCin = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    check_both("async_reset_immediate", 32'h0000_0000, 1'b0);
    @(posedge clk);
    #1;
    check_both("async_reset_held_edge", 32'h0000_0000, 1'b0);

    // First edge after release is a normal capture edge
    @(negedge clk);
    dataCin = 32'hCAFE_0123;
    rst_n   = 1'b1;
    #1;
    check_both("release_before_edge", 32'h0000_0000, 1'b0);
    @(posedge clk);
    #1;
    check_both("first_edge_capture", 32'hCAFE_0123, 1'b1);

    @(negedge clk);
    loadC   = 1'b0;
    dataCin = 32'h0000_0001;
    @(posedge clk);
    #1;
    check_both("final_hold", 32'hCAFE_0123, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
